// File: rtl/dedisp_pkg.sv
// Shared types and helpers for the dedispersion delay-line blocks.
package dedisp_pkg;

  // Controller phase: FILL until `delay` samples are stored, then RUN.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } delay_state_t;

  // Address width for a memory of the given depth (at least 1 bit).
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dedisp_delay_ctrl.sv
// Sequences one registered-read BRAM as a programmable circular delay line:
// every valid input is written, and once `delay` samples are stored each new
// input also reads back the sample written `delay` valid-samples earlier.
module dedisp_delay_ctrl
  import dedisp_pkg::*;
#(
  parameter int N_ADDR        = 256,
  parameter int DATA_WIDTH    = 16,
  parameter int DEFAULT_DELAY = 16,
  localparam int AW           = addr_width(N_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [AW-1:0]         cfg_delay,
  input  logic                  cfg_load,
  output logic                  bram_wen,
  output logic                  bram_ren,
  output logic [AW-1:0]         bram_wadd,
  output logic [AW-1:0]         bram_radd,
  output logic [DATA_WIDTH-1:0] bram_win,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  filling
);

  // A delay of zero would make the read address collide with the write
  // address, so zero is promoted to one everywhere a delay is loaded.
  localparam logic [AW-1:0] DEF_RAW   = AW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] DEF_DELAY = (DEF_RAW == '0) ? AW'(1) : DEF_RAW;

  delay_state_t    state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]   delay_r_q, delay_r_d;
  logic            rd_pend_q, rd_pend_d;
  logic            vld;
  logic [AW-1:0]   new_delay;

  // Input valid is masked during reset so the BRAM is never written then.
  assign vld       = din_valid & rst_n;
  assign new_delay = (cfg_delay == '0) ? AW'(1) : cfg_delay;

  // BRAM port drive: combinational from the current input and state.
  always_comb begin
    bram_wen  = vld;
    bram_wadd = wptr_q;
    bram_win  = din;
    bram_radd = wptr_q - delay_r_q;
    bram_ren  = vld && (state_q == RUN) && !cfg_load;
  end

  // Next-state logic: pointer advance, fill counting and delay reload.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    fill_cnt_d = fill_cnt_q;
    delay_r_d  = delay_r_q;
    rd_pend_d  = bram_ren;

    if (vld) begin
      wptr_d = wptr_q + AW'(1);
    end

    if (cfg_load) begin
      // Reload restarts the fill; a sample arriving now is the first one.
      delay_r_d  = new_delay;
      state_d    = FILL;
      fill_cnt_d = '0;
      if (vld) begin
        if (new_delay == AW'(1)) begin
          state_d = RUN;
        end else begin
          fill_cnt_d = AW'(1);
        end
      end
    end else if (state_q == FILL && vld) begin
      if (fill_cnt_q == delay_r_q - AW'(1)) begin
        state_d    = RUN;
        fill_cnt_d = '0;
      end else begin
        fill_cnt_d = fill_cnt_q + AW'(1);
      end
    end
  end

  // State registers; reset discards any read that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      delay_r_q  <= DEF_DELAY;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      fill_cnt_q <= fill_cnt_d;
      delay_r_q  <= delay_r_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // Output qualification: read data is only meaningful for a pending read.
  always_comb begin
    dout_valid = rd_pend_q;
    dout       = rd_pend_q ? bram_rdata : '0;
    filling    = (state_q == FILL);
  end

endmodule
